// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer owning the PC, imem handshake and the decode instruction register
// Ports:
//   clk, reset (sync, active-low)
//   imem_req/imem_addr -> instruction memory; imem_ack/imem_rdata <- instruction memory
//   stall, redirect_valid, redirect_pc <- decode / branch unit
//   ir_out, ir_valid, pc_out -> decode; fetch_err -> sticky timeout flag
//   perf_fetch_cnt, perf_stall_cnt -> only when FETCH_CTRL_PERF_EN is defined
module fetch_ctrl #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_err
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  typedef enum logic [1:0] {RST, REQ, ISSUE, ERR} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_t            state_q;
  logic [ADDR_W-1:0] pc_q, tgt_q, pc_out_q;
  logic [31:0]       ir_q;
  logic              ir_valid_q, drop_q;
  logic [7:0]        wait_q;
  logic [ADDR_W-1:0] pc_inc_d, rpc_d;
  logic [7:0]        wait_d;
  assign pc_inc_d = pc_q + ADDR_W'(4);
  assign rpc_d    = redirect_pc & ~ADDR_W'(3);
  assign wait_d   = wait_q + 8'd1;
  // A redirect while a request is outstanding is parked in tgt_q: the address
  // must stay stable until the ack, whose data is then thrown away.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RST;
      pc_q       <= RESET_PC;
      tgt_q      <= RESET_PC;
      pc_out_q   <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      drop_q     <= 1'b0;
      wait_q     <= '0;
    end else begin
      case (state_q)
        RST: state_q <= REQ;
        REQ: begin
          if (imem_ack) begin
            wait_q <= '0;
            drop_q <= 1'b0;
            if (redirect_valid) pc_q <= rpc_d;
            else if (drop_q) pc_q <= tgt_q;
            else begin
              ir_q       <= imem_rdata;
              pc_out_q   <= pc_q;
              ir_valid_q <= 1'b1;
              pc_q       <= pc_inc_d;
              state_q    <= ISSUE;
            end
          end else begin
            wait_q <= wait_d;
            if (redirect_valid) begin
              drop_q <= 1'b1;
              tgt_q  <= rpc_d;
            end
            if (wait_d == TMO) state_q <= ERR;
          end
        end
        ISSUE: begin
          if (redirect_valid || !stall) begin
            ir_valid_q <= 1'b0;
            ir_q       <= '0;
            state_q    <= REQ;
            pc_q       <= redirect_valid ? rpc_d : pc_q;
          end
        end
        default: state_q <= ERR;
      endcase
    end
  end
  assign imem_req  = state_q == REQ;
  assign imem_addr = pc_q;
  assign ir_out    = ir_q;
  assign ir_valid  = ir_valid_q;
  assign pc_out    = pc_out_q;
  assign fetch_err = state_q == ERR;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_q + 32'((state_q == REQ) && imem_ack && !redirect_valid && !drop_q);
      perf_stall_q <= perf_stall_q + 32'((state_q == ISSUE) && stall);
    end
  end
  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized self-checking bench for fetch_ctrl against a behavioural model
module tb_fetch_ctrl;
  localparam int TIMEOUT = 15;
  logic        clk = 1'b0;
  logic        reset, imem_ack, stall, redirect_valid;
  logic [31:0] imem_rdata, redirect_pc, imem_addr, ir_out, pc_out;
  logic        imem_req, ir_valid, fetch_err;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif
  always #5 clk = ~clk;
  fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ir_out(ir_out), .ir_valid(ir_valid), .pc_out(pc_out), .fetch_err(fetch_err)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  int n_chk = 0, n_pass = 0;
  bit          m_live, m_have, m_dead, m_drop;
  logic [31:0] m_pc, m_tgt, m_ir, m_pcout, m_fetch, m_stall;
  int          m_wait;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic model(input logic r, input logic a, input logic s, input logic rv,
                       input logic [31:0] rpc, input logic [31:0] rd);
    logic [31:0] al;
    al = {rpc[31:2], 2'b00};
    if (!r) begin
      m_live = 0; m_have = 0; m_dead = 0; m_drop = 0; m_wait = 0;
      m_pc = 0; m_tgt = 0; m_ir = 0; m_pcout = 0; m_fetch = 0; m_stall = 0;
    end else if (!m_live) m_live = 1;
    else if (!m_dead) begin
      if (m_have) begin
        if (s) m_stall++;
        if (rv) begin m_pc = al; m_have = 0; m_ir = 0; end
        else if (!s) begin m_have = 0; m_ir = 0; end
      end else if (a) begin
        m_wait = 0;
        if (rv) begin m_pc = al; m_drop = 0; end
        else if (m_drop) begin m_pc = m_tgt; m_drop = 0; end
        else begin m_ir = rd; m_pcout = m_pc; m_have = 1; m_pc = m_pc + 4; m_fetch++; end
      end else begin
        if (rv) begin m_drop = 1; m_tgt = al; end
        m_wait++;
        if (m_wait == TIMEOUT) m_dead = 1;
      end
    end
  endtask
  task automatic tick(input logic r, input logic a, input logic s, input logic rv,
                      input logic [31:0] rpc, input logic [31:0] rd);
    reset = r; imem_ack = a; stall = s; redirect_valid = rv; redirect_pc = rpc; imem_rdata = rd;
    model(r, a, s, rv, rpc, rd);
    @(posedge clk);
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(m_live && !m_have && !m_dead));
    chk("imem_addr", imem_addr, m_pc);
    chk("ir_valid", 32'(ir_valid), 32'(m_have));
    chk("ir_out", ir_out, m_ir);
    chk("pc_out", pc_out, m_pcout);
    chk("fetch_err", 32'(fetch_err), 32'(m_dead));
`ifdef FETCH_CTRL_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetch);
    chk("perf_stall", perf_stall_cnt, m_stall);
`endif
  endtask
  initial begin
    reset = 0; imem_ack = 0; stall = 0; redirect_valid = 0; redirect_pc = 0; imem_rdata = 0;
    @(negedge clk);
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_err", 32'(fetch_err), 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("rel_req", 32'(imem_req), 1);
    tick(1, 1, 0, 0, 0, 32'h00A00093);
    chk("first_ir", ir_out, 32'h00A00093);
    chk("first_pc", pc_out, 0);
    chk("first_valid", 32'(ir_valid), 1);
    repeat (4) tick(1, 0, 1, 0, 0, 0);
    chk("stall_ir", ir_out, 32'h00A00093);
    chk("stall_req", 32'(imem_req), 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("next_addr", imem_addr, 4);
    chk("next_req", 32'(imem_req), 1);
    tick(1, 0, 0, 1, 32'h103, 0);
    chk("drop_hold_addr", imem_addr, 4);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 32'hDEADBEEF);
    chk("drop_valid", 32'(ir_valid), 0);
    chk("redir_addr", imem_addr, 32'h100);
    tick(1, 1, 0, 0, 0, 32'h12345678);
    chk("redir_pcout", pc_out, 32'h100);
    tick(1, 0, 0, 0, 0, 0);
    repeat (14) tick(1, 0, 0, 0, 0, 0);
    chk("pre_timeout", 32'(fetch_err), 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("timeout_err", 32'(fetch_err), 1);
    chk("timeout_req", 32'(imem_req), 0);
    tick(1, 1, 0, 1, 32'h40, 32'h1);
    chk("err_sticky", 32'(fetch_err), 1);
    chk("err_addr", imem_addr, 32'h104);
    tick(0, 0, 0, 0, 0, 0);
    chk("err_clear", 32'(fetch_err), 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 32'hA);
    tick(1, 0, 0, 1, 32'hFFFFFFFF, 0);
    chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
    tick(1, 1, 0, 0, 0, 32'hB);
    chk("wrap_pcout", pc_out, 32'hFFFFFFFC);
    tick(1, 0, 0, 0, 0, 0);
    chk("wrap_next", imem_addr, 0);
    for (int i = 0; i < 3000; i++) begin
      int   ap;
      logic r, a, s, rv;
      ap = ((i / 400) % 3 == 2) ? 3 : 55;
      a  = (m_live && !m_have && !m_dead) ? 1'($urandom_range(99) < ap) : 1'($urandom_range(9) == 0);
      r  = 1'($urandom_range(199) != 0);
      s  = 1'($urandom_range(1));
      rv = 1'($urandom_range(9) == 0);
      tick(r, a, s, rv, $urandom, $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
